// File: rtl/msu_audio_seq.sv
// MSU-1 audio sequencer: primes the two-half DAC sample buffer, keeps it
// refilled as playback crosses half boundaries, and flags end of track/underrun.
module msu_audio_seq (
  input  logic       clkin,
  input  logic       reset,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_play,
  input  logic       cmd_repeat,
  input  logic       dac_status,
  output logic       dac_reset,
  output logic [8:0] dac_addr_ext,
  output logic       dac_play,
  output logic       fill_req,
  output logic       fill_half,
  input  logic       fill_ack,
  input  logic       fill_eof,
  output logic       loop_restart,
  output logic       busy,
  output logic       playing,
  output logic       underrun,
  output logic       track_end
);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_PRIME0, S_PRIME1, S_PLAY} state_t;

  state_t state_reg;
  logic   status_reg, prev_status_reg;
  logic   eof_valid_reg, eof_half_reg;
  logic   queued_reg, queued_half_reg;

  logic   ack_done, toggle, vacated, end_of_track;
  logic   req_next, half_next, queued_next, queued_half_next, underrun_set;

  assign dac_addr_ext = 9'h000;

  // Fill-slot arbitration while playing: the ack frees the slot first, a queued
  // half takes it next, and only then does a fresh toggle compete for it.
  always_comb begin
    ack_done         = fill_req && fill_ack;
    toggle           = status_reg != prev_status_reg;
    vacated          = ~status_reg;
    end_of_track     = eof_valid_reg && toggle && (vacated == eof_half_reg);
    req_next         = fill_req && !ack_done;
    half_next        = fill_half;
    queued_next      = queued_reg;
    queued_half_next = queued_half_reg;
    underrun_set     = 1'b0;
    if (ack_done && queued_reg) begin
      req_next    = 1'b1;
      half_next   = queued_half_reg;
      queued_next = 1'b0;
    end
    if (toggle && !eof_valid_reg) begin
      if (!req_next) begin
        req_next  = 1'b1;
        half_next = vacated;
      end else begin
        underrun_set = 1'b1;
        if (!queued_next) begin
          queued_next      = 1'b1;
          queued_half_next = vacated;
        end
      end
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      status_reg      <= 1'b0;
      prev_status_reg <= 1'b0;
      eof_valid_reg   <= 1'b0;
      eof_half_reg    <= 1'b0;
      queued_reg      <= 1'b0;
      queued_half_reg <= 1'b0;
      dac_reset       <= 1'b0;
      dac_play        <= 1'b0;
      fill_req        <= 1'b0;
      fill_half       <= 1'b0;
      loop_restart    <= 1'b0;
      busy            <= 1'b0;
      playing         <= 1'b0;
      underrun        <= 1'b0;
      track_end       <= 1'b0;
    end else begin
      status_reg      <= dac_status;
      prev_status_reg <= status_reg;
      dac_reset       <= 1'b0;
      loop_restart    <= 1'b0;
      if (cmd_stop) begin
        state_reg  <= S_IDLE;
        fill_req   <= 1'b0;
        queued_reg <= 1'b0;
        dac_play   <= 1'b0;
        busy       <= 1'b0;
        playing    <= 1'b0;
      end else if (cmd_start) begin
        state_reg     <= S_RST;
        dac_reset     <= 1'b1;
        fill_req      <= 1'b0;
        queued_reg    <= 1'b0;
        eof_valid_reg <= 1'b0;
        underrun      <= 1'b0;
        track_end     <= 1'b0;
        dac_play      <= 1'b0;
        busy          <= 1'b1;
        playing       <= 1'b0;
      end else begin
        // fill_req is only ever high in priming/PLAY, so ack_done is already qualified
        if (ack_done && fill_eof) begin
          if (cmd_repeat) begin
            loop_restart <= 1'b1;
          end else begin
            eof_valid_reg <= 1'b1;
            eof_half_reg  <= fill_half;
          end
        end
        case (state_reg)
          S_IDLE: ;
          S_RST: begin
            state_reg <= S_PRIME0;
            fill_req  <= 1'b1;
            fill_half <= 1'b0;
          end
          S_PRIME0: begin
            if (ack_done) begin
              state_reg <= S_PRIME1;
              fill_half <= 1'b1;
            end
          end
          S_PRIME1: begin
            if (ack_done) begin
              state_reg <= S_PLAY;
              fill_req  <= 1'b0;
              busy      <= 1'b0;
              playing   <= 1'b1;
              dac_play  <= cmd_play;
            end
          end
          S_PLAY: begin
            if (end_of_track) begin
              state_reg  <= S_IDLE;
              track_end  <= 1'b1;
              dac_play   <= 1'b0;
              playing    <= 1'b0;
              fill_req   <= 1'b0;
              queued_reg <= 1'b0;
            end else begin
              dac_play        <= cmd_play;
              fill_req        <= req_next;
              fill_half       <= half_next;
              queued_reg      <= queued_next;
              queued_half_reg <= queued_half_next;
              if (underrun_set) underrun <= 1'b1;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_msu_audio_seq.sv
// Bench for msu_audio_seq: directed vector table, a random fill/toggle run
// against a queue-based model, and an asynchronous reset mid-play.
module tb_msu_audio_seq;

  logic       clkin = 1'b0;
  logic       reset, cmd_start, cmd_stop, cmd_play, cmd_repeat, dac_status;
  logic       fill_ack, fill_eof;
  logic       dac_reset, dac_play, fill_req, fill_half, loop_restart;
  logic       busy, playing, underrun, track_end;
  logic [8:0] dac_addr_ext;

  int total = 0;
  int bad   = 0;

  always #5 clkin = ~clkin;

  msu_audio_seq dut (
    .clkin(clkin), .reset(reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_play(cmd_play), .cmd_repeat(cmd_repeat), .dac_status(dac_status),
    .dac_reset(dac_reset), .dac_addr_ext(dac_addr_ext), .dac_play(dac_play),
    .fill_req(fill_req), .fill_half(fill_half), .fill_ack(fill_ack),
    .fill_eof(fill_eof), .loop_restart(loop_restart), .busy(busy),
    .playing(playing), .underrun(underrun), .track_end(track_end)
  );

  // {dac_reset, dac_play, fill_req, fill_half, loop_restart, busy, playing, underrun, track_end}
  wire [8:0] outs = {dac_reset, dac_play, fill_req, fill_half, loop_restart,
                     busy, playing, underrun, track_end};

  typedef struct {
    logic       start, stop, play, rpt, status, ack, eof;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[37];
  logic q[$];
  logic und;

  function automatic vec_t v(input logic s, p, pl, r, st, a, e, input logic [8:0] x);
    vec_t t;
    t.start = s; t.stop = p; t.play = pl; t.rpt = r;
    t.status = st; t.ack = a; t.eof = e; t.exp = x;
    return t;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  initial begin
    vecs[0]  = v(1,0,1,0,0,0,0, 9'b100001000);
    vecs[1]  = v(0,0,1,0,0,0,0, 9'b001001000);
    vecs[2]  = v(0,0,1,0,0,0,0, 9'b001001000);
    vecs[3]  = v(0,0,1,0,0,1,0, 9'b001101000);
    vecs[4]  = v(0,0,1,0,0,1,0, 9'b010100100);
    vecs[5]  = v(0,0,1,0,1,0,0, 9'b010100100);
    vecs[6]  = v(0,0,1,0,1,0,0, 9'b011000100);
    vecs[7]  = v(0,0,1,0,1,1,0, 9'b010000100);
    vecs[8]  = v(0,0,1,0,0,0,0, 9'b010000100);
    vecs[9]  = v(0,0,1,0,0,0,0, 9'b011100100);
    vecs[10] = v(0,0,1,0,1,0,0, 9'b011100100);
    vecs[11] = v(0,0,1,0,1,0,0, 9'b011100110);
    vecs[12] = v(0,0,1,0,1,1,0, 9'b011000110);
    vecs[13] = v(0,0,1,0,1,1,1, 9'b010000110);
    vecs[14] = v(0,0,1,0,0,0,0, 9'b010000110);
    vecs[15] = v(0,0,1,0,0,0,0, 9'b010000110);
    vecs[16] = v(0,0,1,0,1,0,0, 9'b010000110);
    vecs[17] = v(0,0,1,0,1,0,0, 9'b000000011);
    vecs[18] = v(0,0,1,0,1,1,0, 9'b000000011);
    vecs[19] = v(1,0,1,0,1,0,0, 9'b100001000);
    vecs[20] = v(0,0,1,0,1,0,0, 9'b001001000);
    vecs[21] = v(0,0,1,1,1,1,1, 9'b001111000);
    vecs[22] = v(1,1,1,0,1,0,0, 9'b000100000);
    vecs[23] = v(0,0,1,0,1,1,0, 9'b000100000);
    vecs[24] = v(1,0,1,0,1,0,0, 9'b100101000);
    vecs[25] = v(0,0,1,0,1,0,0, 9'b001001000);
    vecs[26] = v(0,0,1,0,1,1,0, 9'b001101000);
    vecs[27] = v(0,0,0,0,1,1,0, 9'b000100100);
    vecs[28] = v(0,0,1,0,1,0,0, 9'b010100100);
    vecs[29] = v(0,0,1,0,0,0,0, 9'b010100100);
    vecs[30] = v(0,0,1,0,0,0,0, 9'b011100100);
    vecs[31] = v(0,0,1,1,0,1,1, 9'b010110100);
    vecs[32] = v(0,0,1,0,1,0,0, 9'b010100100);
    vecs[33] = v(0,0,1,0,1,0,0, 9'b011000100);
    vecs[34] = v(0,0,1,0,0,0,0, 9'b011000100);
    vecs[35] = v(0,0,1,0,0,1,0, 9'b011100100);
    vecs[36] = v(0,1,1,0,0,0,0, 9'b000100000);

    reset = 1'b1; cmd_start = 0; cmd_stop = 0; cmd_play = 1; cmd_repeat = 0;
    dac_status = 0; fill_ack = 0; fill_eof = 0;
    tick(); tick();
    chk("reset outputs", int'(outs), 0);
    chk("reset dac_addr_ext", int'(dac_addr_ext), 0);
    reset = 1'b0;
    tick();
    chk("idle after reset", int'(outs), 0);

    for (int i = 0; i < 37; i++) begin
      cmd_start = vecs[i].start; cmd_stop = vecs[i].stop; cmd_play = vecs[i].play;
      cmd_repeat = vecs[i].rpt; dac_status = vecs[i].status;
      fill_ack = vecs[i].ack; fill_eof = vecs[i].eof;
      tick();
      chk($sformatf("vector %0d outs", i), int'(outs), int'(vecs[i].exp));
    end
    cmd_start = 0; cmd_stop = 0; fill_ack = 0; fill_eof = 0;

    // Random toggles and acks in PLAY against a FIFO of halves awaiting refill
    cmd_repeat = 1; cmd_play = 1;
    cmd_start = 1; tick(); cmd_start = 0; tick();
    fill_ack = 1; tick(); tick(); fill_ack = 0;
    chk("random prime playing", int'(playing), 1);
    und = 1'b0;
    for (int e = 0; e < 150; e++) begin
      cmd_play = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0 && q.size() > 0) begin
        fill_ack = 1; fill_eof = 1'($urandom_range(0, 1));
        tick();
        chk($sformatf("rand %0d loop_restart", e), int'(loop_restart), int'(fill_eof));
        fill_ack = 0; fill_eof = 0;
        void'(q.pop_front());
        tick(); tick();
      end else begin
        dac_status = ~dac_status;
        if (q.size() > 0) und = 1'b1;
        if (q.size() < 2) q.push_back(~dac_status);
        tick(); tick(); tick();
      end
      chk($sformatf("rand %0d fill_req", e), int'(fill_req), int'(q.size() > 0));
      if (q.size() > 0)
        chk($sformatf("rand %0d fill_half", e), int'(fill_half), int'(q[0]));
      chk($sformatf("rand %0d underrun", e), int'(underrun), int'(und));
      chk($sformatf("rand %0d dac_play", e), int'(dac_play), int'(cmd_play));
    end

    // Asynchronous reset in the middle of a cycle while playing
    cmd_play = 1; dac_status = ~dac_status;
    tick(); tick(); tick();
    chk("pre-reset playing", int'(playing), 1);
    #2 reset = 1'b1;
    #1;
    chk("async reset outputs", int'(outs), 0);
    chk("async reset dac_addr_ext", int'(dac_addr_ext), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("post-reset idle", int'(outs), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
